// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch (IF) requester
//   and the load/store (DM) requester. A winner is picked in IDLE, the memory is
//   held for MEM_LATENCY busy cycles, the read data is registered on the last
//   busy cycle, and a one-cycle ack is returned in DONE.
//
//   Handshake: a requester raises req with its address/data and holds all of
//   them stable until it sees its one-cycle ack; the grant is never preempted,
//   and the ack always pulses once the access has started.
//
//   Optional build macro FAIR_RR_EN: when defined, simultaneous requests are
//   resolved round-robin against the previous grant; when undefined, DM always
//   wins a tie.
//
//   state_dbg_o exposes the FSM state (0 = IDLE, 1 = BUSY, 2 = DONE).
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [31:0] port_rdata,
    output logic        port_sel,
    output logic        port_en,
    output logic        port_we,
    output logic [31:0] rdata,
    output logic        if_ack,
    output logic        dm_ack,
    output logic        if_stall,
    output logic        dm_stall,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter preload: the counter runs MEM_LATENCY-1 down to 0 inclusive.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;       // 0 = IF path, 1 = DM path
    logic        we_q, we_d;         // dm_we latched at grant
    logic [31:0] rdata_q, rdata_d;
    logic        grant_dm;

`ifdef FAIR_RR_EN
    logic        last_grant_q, last_grant_d;   // 0 = IF, 1 = DM
`endif

    // The memory address/data muxes sit outside this block; only their select
    // is produced here, so the request payloads are not consumed.
    logic unused_ok;
    assign unused_ok = ^{if_addr, dm_addr, dm_wdata};

    // Arbitration winner for an IDLE-cycle grant.
`ifdef FAIR_RR_EN
    assign grant_dm = dm_req & (~if_req | ~last_grant_q);
`else
    assign grant_dm = dm_req;
`endif

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
`ifdef FAIR_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req | dm_req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    sel_d   = grant_dm;
                    we_d    = grant_dm & dm_we;
`ifdef FAIR_RR_EN
                    last_grant_d = grant_dm;
`endif
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = port_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
`ifdef FAIR_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef FAIR_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Outputs decode directly from registered state so they drop with reset.
    always_comb begin
        port_sel    = sel_q;
        port_en     = (state_q == BUSY);
        port_we     = (state_q == BUSY) & sel_q & we_q;
        rdata       = rdata_q;
        if_ack      = (state_q == DONE) & ~sel_q;
        dm_ack      = (state_q == DONE) & sel_q;
        if_stall    = if_req & ~if_ack;
        dm_stall    = dm_req & ~dm_ack;
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps followed by randomized traffic
// checked against a transaction-timeline model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, port_rdata;

    logic        port_sel, port_en, port_we, if_ack, dm_ack, if_stall, dm_stall;
    logic [31:0] rdata;
    logic [1:0]  state_dbg;

    logic        a_sel, a_en, a_we, a_if_ack, a_dm_ack, a_if_stall, a_dm_stall;
    logic [31:0] a_rdata;
    logic [1:0]  a_state;
    logic        b_sel, b_en, b_we, b_if_ack, b_dm_ack, b_if_stall, b_dm_stall;
    logic [31:0] b_rdata;
    logic [1:0]  b_state;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .port_rdata(port_rdata), .port_sel(port_sel), .port_en(port_en),
        .port_we(port_we), .rdata(rdata), .if_ack(if_ack), .dm_ack(dm_ack),
        .if_stall(if_stall), .dm_stall(dm_stall), .state_dbg_o(state_dbg)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .port_rdata(port_rdata), .port_sel(a_sel), .port_en(a_en),
        .port_we(a_we), .rdata(a_rdata), .if_ack(a_if_ack), .dm_ack(a_dm_ack),
        .if_stall(a_if_stall), .dm_stall(a_dm_stall), .state_dbg_o(a_state)
    );

    mem_port_arbiter #(.MEM_LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .port_rdata(port_rdata), .port_sel(b_sel), .port_en(b_en),
        .port_we(b_we), .rdata(b_rdata), .if_ack(b_if_ack), .dm_ack(b_dm_ack),
        .if_stall(b_if_stall), .dm_stall(b_dm_stall), .state_dbg_o(b_state)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic clear_inputs();
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; port_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // reference-model state for the random phase
    int          g, free_at;
    bit          own, twe, lg, win, if_pend, dm_pend, exp_en, exp_ifa, exp_dma;
    logic [31:0] mdl_rd, saved_rd;
    int          a_first, b_first, a_cnt, b_cnt, acks;
    bit          exp_win;

    initial begin
        // ---- reset values (asynchronous, before any clock edge)
        reset = 1'b1;
        clear_inputs();
        #3;
        chk("rst_port_sel", 32'(port_sel), 0);
        chk("rst_port_en",  32'(port_en),  0);
        chk("rst_port_we",  32'(port_we),  0);
        chk("rst_rdata",    rdata,         0);
        chk("rst_if_ack",   32'(if_ack),   0);
        chk("rst_dm_ack",   32'(dm_ack),   0);
        do_reset();

        // ---- reset in the middle of a store
        @(posedge clk); #1;
        dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
        port_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midbusy_en_before", 32'(port_en), 1);
        chk("midbusy_we_before", 32'(port_we), 1);
        #2 reset = 1'b1;
        #1;
        chk("midbusy_en_after", 32'(port_en), 0);
        chk("midbusy_we_after", 32'(port_we), 0);
        chk("midbusy_ack",      32'(dm_ack),  0);
        dm_req = 0; dm_we = 0;
        @(posedge clk); #1 reset = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(dm_ack) + int'(if_ack) + int'(port_en);
        end
        chk("midbusy_no_activity", 32'(acks), 0);
        chk("midbusy_rdata", rdata, 0);

        // ---- single fetch, L=2
        do_reset();
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h0040_0000; port_rdata = 32'h2008_0005;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 4) if_req = 0;
            @(negedge clk);
            chk($sformatf("fetch_en_c%0d", c), 32'(port_en), 32'(c >= 1 && c <= 2));
            chk($sformatf("fetch_ack_c%0d", c), 32'(if_ack), 32'(c == 3));
            chk($sformatf("fetch_stall_c%0d", c), 32'(if_stall), 32'(c <= 2));
            if (c >= 1 && c <= 2) chk($sformatf("fetch_sel_c%0d", c), 32'(port_sel), 0);
            if (c == 3) chk("fetch_rdata", rdata, 32'h2008_0005);
        end

        // ---- single store, L=2
        @(posedge clk); #1;
        dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 4) begin dm_req = 0; dm_we = 0; end
            @(negedge clk);
            chk($sformatf("store_we_c%0d", c), 32'(port_we), 32'(c >= 1 && c <= 2));
            chk($sformatf("store_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
            chk($sformatf("store_stall_c%0d", c), 32'(dm_stall), 32'(c <= 2));
            if (c >= 1 && c <= 2) chk($sformatf("store_sel_c%0d", c), 32'(port_sel), 1);
        end

        // ---- simultaneous requests: DM first, then IF after one IDLE bubble
        do_reset();
        @(posedge clk); #1;
        if_req = 1; dm_req = 1; dm_we = 0; port_rdata = 32'h0BAD_F00D;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 4) dm_req = 0;
            if (c == 8) if_req = 0;
            @(negedge clk);
            chk($sformatf("tie_dm_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
            chk($sformatf("tie_if_ack_c%0d", c), 32'(if_ack), 32'(c == 7));
            chk($sformatf("tie_if_stall_c%0d", c), 32'(if_stall), 32'(c <= 6));
            chk($sformatf("tie_en_c%0d", c), 32'(port_en),
                32'(c == 1 || c == 2 || c == 5 || c == 6));
            if (c == 1 || c == 2) chk($sformatf("tie_sel_c%0d", c), 32'(port_sel), 1);
            if (c == 5 || c == 6) chk($sformatf("tie_sel_c%0d", c), 32'(port_sel), 0);
        end

        // ---- both held for four transactions: grant order
        do_reset();
        @(posedge clk); #1;
        if_req = 1; dm_req = 1; dm_we = 0;
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (c % 4 == 3) begin
`ifdef FAIR_RR_EN
                exp_win = ((c / 4) % 2 == 0);
`else
                exp_win = 1'b1;
`endif
                chk($sformatf("order_dm_ack_t%0d", c / 4), 32'(dm_ack), 32'(exp_win));
                chk($sformatf("order_if_ack_t%0d", c / 4), 32'(if_ack), 32'(!exp_win));
            end
        end

        // ---- latency extremes: L=1 and L=15 instances
        do_reset();
        a_first = -1; b_first = -1; a_cnt = 0; b_cnt = 0;
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h0040_0010;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (a_first < 0 && a_en) a_cnt++;
            if (b_first < 0 && b_en) b_cnt++;
            if (a_first < 0 && a_if_ack) a_first = c;
            if (b_first < 0 && b_if_ack) b_first = c;
        end
        chk("lat1_ack_cycle",  32'(a_first), 2);
        chk("lat1_en_cycles",  32'(a_cnt),   1);
        chk("lat15_ack_cycle", 32'(b_first), 16);
        chk("lat15_en_cycles", 32'(b_cnt),   15);

        // ---- randomized traffic against the timeline model
        do_reset();
        g = -100; free_at = 0; own = 0; twe = 0; lg = 0;
        if_pend = 0; dm_pend = 0; mdl_rd = 0; saved_rd = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            // requester that was acked last cycle retires its request
            if (k - 1 == g + L + 1) begin
                if (own) dm_pend = 0; else if_pend = 0;
            end
            if (k == g + L + 1) mdl_rd = saved_rd;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            if_req = if_pend; dm_req = dm_pend;
            port_rdata = $urandom;
            if (k == g + L) saved_rd = port_rdata;
            if (k >= free_at && (if_pend || dm_pend)) begin
`ifdef FAIR_RR_EN
                win = (if_pend && dm_pend) ? !lg : dm_pend;
`else
                win = dm_pend;
`endif
                g = k; own = win; twe = win & dm_we; lg = win;
                free_at = k + L + 2;
            end
            @(negedge clk);
            exp_en  = (k > g) && (k <= g + L);
            exp_ifa = (k == g + L + 1) && !own;
            exp_dma = (k == g + L + 1) && own;
            chk("rnd_port_en", 32'(port_en), 32'(exp_en));
            chk("rnd_port_we", 32'(port_we), 32'(exp_en && own && twe));
            if (exp_en) chk("rnd_port_sel", 32'(port_sel), 32'(own));
            chk("rnd_if_ack", 32'(if_ack), 32'(exp_ifa));
            chk("rnd_dm_ack", 32'(dm_ack), 32'(exp_dma));
            chk("rnd_if_stall", 32'(if_stall), 32'(if_req && !exp_ifa));
            chk("rnd_dm_stall", 32'(dm_stall), 32'(dm_req && !exp_dma));
            chk("rnd_rdata", rdata, mdl_rd);
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
